// File: rtl/tybec_axis_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tybec_axis_pkg
//  Description : Shared constants and helpers for the TyBEC AXI-stream wrapper
//  Revision    : 1.0
// ============================================================================
package tybec_axis_pkg;

    localparam int TY_MAX_CHANNELS = 8;
    localparam int TY_GVECT        = 8;

    // One channel beat at the default vector width (32 * TY_GVECT bits).
    typedef logic [32*TY_GVECT-1:0] ty_gvect_word_t;

    // Pointer width for a given depth, never less than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tybec_fifo_fwft.sv
`default_nettype none
// ============================================================================
//  Module      : tybec_fifo_fwft
//  Description : First-word-fall-through FIFO with count-based full/empty
//  Revision    : 1.0
// ============================================================================
module tybec_fifo_fwft
    import tybec_axis_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_nonempty
);

    localparam int PTR_W = clog2_min1(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             w_push;
    logic             w_pop;

    // Ready comes from the count alone: a full FIFO refuses even when popping.
    assign o_ready    = !rst && (count_q != C_FULL);
    assign o_nonempty = (count_q != '0);
    assign o_data     = mem_q[rd_ptr_q];
    assign w_push     = i_valid && o_ready;
    assign w_pop      = i_pop && o_nonempty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_join_skid.sv
`default_nettype none
// ============================================================================
//  Module      : axis_join_skid
//  Description : N-channel AXI-stream join via FWFT FIFOs, 2-entry output skid
//  Revision    : 1.0
// ============================================================================
module axis_join_skid
    import tybec_axis_pkg::*;
#(
    parameter int C_DATA_WIDTH   = 32 * TY_GVECT,
    parameter int C_NUM_CHANNELS = 2,
    parameter int C_FIFO_DEPTH   = 4,
    parameter int C_STAT_WIDTH   = 32
) (
    input  logic                                         aclk,
    input  logic                                         areset,
    input  logic [C_NUM_CHANNELS-1:0]                    s_tvalid,
    input  logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]  s_tdata,
    output logic [C_NUM_CHANNELS-1:0]                    s_tready,
    output logic                                         c_ivalid,
    output logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]  c_idata,
    input  logic                                         c_iready,
    input  logic                                         c_ovalid,
    input  logic [C_DATA_WIDTH-1:0]                      c_odata,
    output logic                                         c_oready,
    output logic                                         m_tvalid,
    output logic [C_DATA_WIDTH-1:0]                      m_tdata,
    input  logic                                         m_tready,
    output logic [C_STAT_WIDTH-1:0]                      stat_beats_in,
    output logic [C_STAT_WIDTH-1:0]                      stat_beats_out
);

    typedef logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0] beat_arr_t;

    beat_arr_t                 w_heads;
    logic [C_NUM_CHANNELS-1:0] w_nonempty;
    logic                      w_join_pop;

    generate
        for (genvar gi = 0; gi < C_NUM_CHANNELS; gi++) begin : g_ch
            tybec_fifo_fwft #(
                .WIDTH (C_DATA_WIDTH),
                .DEPTH (C_FIFO_DEPTH)
            ) u_fifo (
                .clk        (aclk),
                .rst        (areset),
                .i_valid    (s_tvalid[gi]),
                .i_data     (s_tdata[gi]),
                .o_ready    (s_tready[gi]),
                .i_pop      (w_join_pop),
                .o_data     (w_heads[gi]),
                .o_nonempty (w_nonempty[gi])
            );
        end
    endgenerate

    // Every FIFO pops together so channel beats stay aligned.
    assign c_ivalid   = !areset && (&w_nonempty);
    assign c_idata    = w_heads;
    assign w_join_pop = c_ivalid && c_iready;

    // Output skid: entry0 is always the head, entry1 holds the overflow beat.
    logic [1:0]              ocount_q, ocount_d;
    logic [C_DATA_WIDTH-1:0] entry0_q, entry0_d;
    logic [C_DATA_WIDTH-1:0] entry1_q, entry1_d;
    logic                    w_opush;
    logic                    w_opop;

    assign c_oready = !areset && (ocount_q != 2'd2);
    assign m_tvalid = !areset && (ocount_q != 2'd0);
    assign m_tdata  = entry0_q;
    assign w_opush  = c_ovalid && c_oready;
    assign w_opop   = m_tvalid && m_tready;

    always_comb begin
        ocount_d = ocount_q;
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        case ({w_opush, w_opop})
            2'b10: begin
                ocount_d = ocount_q + 2'd1;
                if (ocount_q == 2'd0) begin
                    entry0_d = c_odata;
                end else begin
                    entry1_d = c_odata;
                end
            end
            2'b01: begin
                ocount_d = ocount_q - 2'd1;
                entry0_d = entry1_q;
            end
            2'b11: begin
                // Only reachable with one entry held, so the new beat becomes head.
                entry0_d = c_odata;
            end
            default: begin
            end
        endcase
    end

    logic [C_STAT_WIDTH-1:0] beats_in_q, beats_in_d;
    logic [C_STAT_WIDTH-1:0] beats_out_q, beats_out_d;

    always_comb begin
        beats_in_d  = beats_in_q + C_STAT_WIDTH'(w_join_pop);
        beats_out_d = beats_out_q + C_STAT_WIDTH'(w_opop);
    end

    assign stat_beats_in  = beats_in_q;
    assign stat_beats_out = beats_out_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            ocount_q    <= 2'd0;
            beats_in_q  <= '0;
            beats_out_q <= '0;
        end else begin
            ocount_q    <= ocount_d;
            beats_in_q  <= beats_in_d;
            beats_out_q <= beats_out_d;
        end
    end

    always_ff @(posedge aclk) begin
        entry0_q <= entry0_d;
        entry1_q <= entry1_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_join_skid.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_join_skid
//  Description : Randomized queue-model bench for axis_join_skid
//  Revision    : 1.0
// ============================================================================
module tb_axis_join_skid;

    localparam int DW    = 32;
    localparam int NCH   = 2;
    localparam int DEPTH = 4;
    localparam int SW    = 4;

    logic                     aclk = 1'b0;
    logic                     areset;
    logic [NCH-1:0]           s_tvalid;
    logic [NCH-1:0][DW-1:0]   s_tdata;
    logic [NCH-1:0]           s_tready;
    logic                     c_ivalid;
    logic [NCH-1:0][DW-1:0]   c_idata;
    logic                     c_iready;
    logic                     c_ovalid;
    logic [DW-1:0]            c_odata;
    logic                     c_oready;
    logic                     m_tvalid;
    logic [DW-1:0]            m_tdata;
    logic                     m_tready;
    logic [SW-1:0]            stat_beats_in;
    logic [SW-1:0]            stat_beats_out;

    axis_join_skid #(
        .C_DATA_WIDTH   (DW),
        .C_NUM_CHANNELS (NCH),
        .C_FIFO_DEPTH   (DEPTH),
        .C_STAT_WIDTH   (SW)
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .s_tvalid       (s_tvalid),
        .s_tdata        (s_tdata),
        .s_tready       (s_tready),
        .c_ivalid       (c_ivalid),
        .c_idata        (c_idata),
        .c_iready       (c_iready),
        .c_ovalid       (c_ovalid),
        .c_odata        (c_odata),
        .c_oready       (c_oready),
        .m_tvalid       (m_tvalid),
        .m_tdata        (m_tdata),
        .m_tready       (m_tready),
        .stat_beats_in  (stat_beats_in),
        .stat_beats_out (stat_beats_out)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // Reference state: per-channel beat queues, the core's pending results,
    // the sink-side buffer contents and the two beat tallies.
    logic [DW-1:0] fq [NCH][$];
    logic [DW-1:0] cq [$];
    logic [DW-1:0] sq [$];
    int            cnt_in;
    int            cnt_out;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] core_fn(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0001;
    endfunction

    task automatic run(input int n, input int pv, input int pi, input int po,
                       input int pm, input int prst);
        for (int c = 0; c < n; c++) begin
            logic         exp_sr [NCH];
            logic         exp_iv;
            logic         exp_or;
            logic         exp_mv;
            logic [DW-1:0] res;
            @(negedge aclk);
            areset   = ($urandom_range(99) < prst);
            for (int i = 0; i < NCH; i++) begin
                s_tvalid[i] = ($urandom_range(99) < pv);
                s_tdata[i]  = $urandom;
            end
            c_iready = ($urandom_range(99) < pi);
            c_ovalid = (cq.size() != 0) && ($urandom_range(99) < po);
            c_odata  = c_ovalid ? cq[0] : $urandom;
            m_tready = ($urandom_range(99) < pm);
            #1;

            exp_iv = !areset;
            for (int i = 0; i < NCH; i++) begin
                exp_sr[i] = !areset && (fq[i].size() < DEPTH);
                check("s_tready", 64'(s_tready[i]), 64'(exp_sr[i]));
                if (fq[i].size() == 0) exp_iv = 1'b0;
            end
            check("c_ivalid", 64'(c_ivalid), 64'(exp_iv));
            if (exp_iv) begin
                for (int i = 0; i < NCH; i++) begin
                    check("c_idata", 64'(c_idata[i]), 64'(fq[i][0]));
                end
            end
            exp_or = !areset && (sq.size() < 2);
            exp_mv = !areset && (sq.size() > 0);
            check("c_oready", 64'(c_oready), 64'(exp_or));
            check("m_tvalid", 64'(m_tvalid), 64'(exp_mv));
            if (exp_mv) check("m_tdata", 64'(m_tdata), 64'(sq[0]));
            check("stat_in", 64'(stat_beats_in), 64'(cnt_in));
            check("stat_out", 64'(stat_beats_out), 64'(cnt_out));

            if (areset) begin
                for (int i = 0; i < NCH; i++) fq[i].delete();
                cq.delete();
                sq.delete();
                cnt_in  = 0;
                cnt_out = 0;
            end else begin
                if (exp_iv && c_iready) begin
                    res = core_fn(fq[0][0], fq[NCH-1][0]);
                    for (int i = 0; i < NCH; i++) void'(fq[i].pop_front());
                    cq.push_back(res);
                    cnt_in = (cnt_in + 1) % (1 << SW);
                end
                for (int i = 0; i < NCH; i++) begin
                    if (s_tvalid[i] && exp_sr[i]) fq[i].push_back(s_tdata[i]);
                end
                if (exp_mv && m_tready) begin
                    void'(sq.pop_front());
                    cnt_out = (cnt_out + 1) % (1 << SW);
                end
                if (c_ovalid && exp_or) begin
                    sq.push_back(c_odata);
                    void'(cq.pop_front());
                end
            end
        end
    endtask

    initial begin
        areset   = 1'b1;
        s_tvalid = '0;
        s_tdata  = '0;
        c_iready = 1'b0;
        c_ovalid = 1'b0;
        c_odata  = '0;
        m_tready = 1'b0;
        cnt_in   = 0;
        cnt_out  = 0;

        run(2, 0, 0, 0, 0, 100);       // power-on reset
        run(24, 100, 100, 100, 100, 0); // full-rate streaming
        run(6, 100, 0, 100, 100, 0);    // core stalled: FIFOs fill
        run(8, 100, 100, 100, 0, 0);    // sink stalled: skid fills
        run(10, 100, 100, 100, 100, 0);
        run(3, 100, 0, 0, 100, 0);      // build up buffered beats
        run(1, 0, 0, 0, 0, 100);        // mid-stream reset
        run(300, 60, 70, 70, 70, 0);
        run(300, 90, 50, 80, 40, 1);
        run(200, 30, 90, 90, 90, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_join_skid.md
Name: axis_join_skid

Overview:
- Parametrised successor of the kernel top-level stream wrapper: N independent AXI-stream input channels, a synchronised single-handshake core interface, and a buffered AXI-stream output.
- Per-channel FWFT FIFOs absorb skew between channels, so each s_tready depends only on that channel's occupancy, not on the other channels' tvalid.
- A 2-entry output skid buffer registers the core output, so m_tready never reaches the core's oready combinationally.
- Sits between the SDx AXI-stream ports and the generated "main" kernel.

Parameters:
- C_DATA_WIDTH, 256, bits per channel beat (32 * TY_GVECT); legal 32..512, multiple of 32.
- C_NUM_CHANNELS, 2, input channel count; legal 1..8.
- C_FIFO_DEPTH, 4, entries per input FIFO; power of 2, at least 2.
- C_STAT_WIDTH, 32, width of the beat counters.

Ports:
- aclk  in  1  clock.
- areset  in  1  reset. Synchronous, active-high.
- s_tvalid  in  [C_NUM_CHANNELS]  per-channel input valid.
- s_tdata  in  [C_NUM_CHANNELS][C_DATA_WIDTH]  per-channel input data.
- s_tready  out  [C_NUM_CHANNELS]  per-channel ready.
- c_ivalid  out  1  joined beat valid to the core.
- c_idata  out  [C_NUM_CHANNELS][C_DATA_WIDTH]  joined data; element i is the head of FIFO i.
- c_iready  in  1  core ready (back-pressure).
- c_ovalid  in  1  core output valid.
- c_odata  in  C_DATA_WIDTH  core output data.
- c_oready  out  1  ready to the core.
- m_tvalid  out  1  output valid.
- m_tdata  out  C_DATA_WIDTH  output data.
- m_tready  in  1  sink ready.
- stat_beats_in  out  C_STAT_WIDTH  joined beats consumed by the core.
- stat_beats_out  out  C_STAT_WIDTH  beats accepted by the sink.

Behaviour:
- Reset, while areset is high:
  - All FIFO and skid counts are cleared and the counters are 0.
  - s_tready=0, c_ivalid=0, c_oready=0, m_tvalid=0. m_tdata and c_idata are don't-care.
  - A reset asserted mid-transfer discards all buffered beats. The first cycle after reset has s_tready all 1 and c_oready=1.
- Input FIFO i:
  - Push when s_tvalid[i] & s_tready[i].
  - s_tready[i] = !areset & (count_i != C_FIFO_DEPTH). It is derived from registered state only.
  - When the FIFO is full, a push is refused even if a pop happens in the same cycle (no full pass-through).
  - Simultaneous push and pop on a non-full FIFO leaves the count unchanged.
  - Pointers wrap modulo C_FIFO_DEPTH.
- Join:
  - c_ivalid = AND over i of (count_i != 0).
  - pop = c_ivalid & c_iready pops every FIFO in the same cycle.
  - No FIFO ever pops alone; per-channel beat alignment is preserved.
- Input latency: a beat pushed at edge k can appear on c_ivalid in cycle k+1 at the earliest.
- Throughput: 1 beat/cycle when all channels stream and the core is ready.
- Output skid, 2 entries:
  - c_oready = !areset & (ocount != 2). m_tvalid = (ocount != 0). m_tdata = head entry.
  - Push on c_ovalid & c_oready. Pop on m_tvalid & m_tready. Push and pop in the same cycle are both honoured.
  - Output latency 1 cycle. Full rate is sustained while m_tready=1.
- Counters:
  - stat_beats_in increments on each join pop. stat_beats_out increments on each m handshake.
  - Both wrap modulo 2^C_STAT_WIDTH without saturation.
- C_NUM_CHANNELS=1 degenerates to FIFO plus skid with identical rules.
- No X propagation: c_idata for an empty FIFO reads its stale RAM word; c_ivalid is 0 in that case.

Decomposition:
- Package tybec_axis_pkg:
  - Constants TY_MAX_CHANNELS=8 and TY_GVECT.
  - Function clog2_min1 for pointer widths.
  - Typedef of a packed channel-beat array parametrised via localparams in the user module.
- Sub-module tybec_fifo_fwft: parametrised width/depth, count-based full/empty, instantiated once per channel with a generate loop.
- The output skid is inline (about 30 lines).

Test Plan:
- Both channels valid every cycle, c_iready=1, m_tready=1, 16 incrementing beats.
  - c_ivalid first high 1 cycle after the first push; 16 m beats in order, with no gaps after fill.
  - stat_beats_in = stat_beats_out = 16.
- Skew: ch0 sends beats 0xA0..0xA3 at cycles 0-3; ch1 sends 0xB0..0xB3 starting at cycle 3.
  - s_tready[0] stays high through cycle 3 (depth 4).
  - c_idata pairs come out exactly (A0,B0)..(A3,B3).
- Fill: c_iready=0 while ch0 pushes 5 beats.
  - s_tready[0] drops after the 4th push; the 5th is held.
  - With c_iready=1, the held beat is accepted 1 cycle after the first pop.
- Output back-pressure: m_tready=0 for 5 cycles during streaming.
  - c_oready falls once 2 entries are held; no beat lost or duplicated.
  - m_tdata is stable while m_tvalid & !m_tready.
- Reset mid-stream: areset for 1 cycle with both FIFOs holding 3 beats.
  - Next cycle all counts are 0, m_tvalid=0, s_tready all 1, counters 0.
- Counter wrap with C_STAT_WIDTH=4: 17 beats -> stat_beats_out = 1.
